// File: rtl/rv32_exec_unit.sv
// RV32I execute stage: immediate decode, integer ALU and branch condition, with EX/MEM registered copies.
// Build option ALU_SHARED_SHIFTER_EN: one right shifter serves SLL/SRL/SRA (results identical either way).
module rv32_exec_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [31:0] inst,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] imm,
  output logic [31:0] result,
  output logic        take_b,
  output logic [31:0] imm_q,
  output logic [31:0] result_q,
  output logic        take_b_q
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } funct3_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_funct3_e;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic [4:0]  shamt;
  logic        is_op;
  logic        is_alu_op;
  logic        is_branch;

  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign alt       = inst[30];
  assign shamt     = in_b[4:0];
  assign is_op     = (opcode == OPC_OP);
  assign is_alu_op = is_op || (opcode == OPC_OP_IMM);
  assign is_branch = (opcode == OPC_BRANCH);

  // Immediate decode
  always_comb begin
    imm = '0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'h000};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  // One zero-extended 33-bit subtract: bit 32 is the unsigned borrow, and
  // XOR with both operand signs turns it into the signed less-than.
  logic [32:0] diff;
  logic [31:0] sum;
  logic        lt_u;
  logic        lt_s;
  logic        eq;

  assign diff = {1'b0, in_a} - {1'b0, in_b};
  assign sum  = in_a + in_b;
  assign lt_u = diff[32];
  assign lt_s = diff[32] ^ in_a[31] ^ in_b[31];
  assign eq   = (diff[31:0] == '0);

  logic [31:0] shl;
  logic [31:0] shr;

`ifdef ALU_SHARED_SHIFTER_EN
  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = v[31 - i];
    end
    return r;
  endfunction

  logic        is_left;
  logic        fill;
  logic [31:0] sh_in;
  logic [31:0] sh_out;

  assign is_left = (funct3 == F3_SLL);
  assign fill    = alt && !is_left && in_a[31];
  assign sh_in   = is_left ? bit_rev(in_a) : in_a;
  assign sh_out  = 32'($signed({fill, sh_in}) >>> shamt);
  assign shl     = bit_rev(sh_out);
  assign shr     = sh_out;
`else
  always_comb begin
    shl = in_a << shamt;
    if (alt) begin
      shr = 32'($signed(in_a) >>> shamt);
    end else begin
      shr = in_a >> shamt;
    end
  end
`endif

  // ALU
  always_comb begin
    result = sum;
    if (is_alu_op) begin
      case (funct3)
        F3_ADD:  result = (is_op && alt) ? diff[31:0] : sum;
        F3_SLL:  result = shl;
        F3_SLT:  result = {31'b0, lt_s};
        F3_SLTU: result = {31'b0, lt_u};
        F3_XOR:  result = in_a ^ in_b;
        F3_SR:   result = shr;
        F3_OR:   result = in_a | in_b;
        F3_AND:  result = in_a & in_b;
        default: result = sum;
      endcase
    end
  end

  // Branch condition
  always_comb begin
    take_b = 1'b0;
    if (is_branch) begin
      case (funct3)
        BR_EQ:   take_b = eq;
        BR_NE:   take_b = !eq;
        BR_LT:   take_b = lt_s;
        BR_GE:   take_b = !lt_s;
        BR_LTU:  take_b = lt_u;
        BR_GEU:  take_b = !lt_u;
        default: take_b = 1'b0;
      endcase
    end
  end

  // EX/MEM registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      imm_q    <= '0;
      result_q <= '0;
      take_b_q <= 1'b0;
    end else if (en) begin
      imm_q    <= imm;
      result_q <= result;
      take_b_q <= take_b;
    end
  end

endmodule

// File: tb/tb_rv32_exec_unit.sv
// Self-checking bench for rv32_exec_unit: directed vectors plus a random compare against a behavioural model.
module tb_rv32_exec_unit;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [31:0] inst;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] imm;
  logic [31:0] result;
  logic        take_b;
  logic [31:0] imm_q;
  logic [31:0] result_q;
  logic        take_b_q;

  int checks;
  int errors;

  rv32_exec_unit dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .inst     (inst),
    .in_a     (in_a),
    .in_b     (in_b),
    .imm      (imm),
    .result   (result),
    .take_b   (take_b),
    .imm_q    (imm_q),
    .result_q (result_q),
    .take_b_q (take_b_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference, written from the ISA definitions
  function automatic logic [31:0] model_imm(input logic [31:0] i);
    logic [31:0] r;
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: r = 32'($signed(i[31:20]));
      7'b0100011: r = 32'($signed({i[31:25], i[11:7]}));
      7'b1100011: r = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      7'b0110111, 7'b0010111: r = {i[31:12], 12'h000};
      7'b1101111: r = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] model_alu(input logic [31:0] i, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    int unsigned sh;
    sh = b % 32;
    r  = a + b;
    if (i[6:0] == 7'b0110011 || i[6:0] == 7'b0010011) begin
      case (i[14:12])
        3'd0: r = (i[6:0] == 7'b0110011 && i[30]) ? a - b : a + b;
        3'd1: r = a << sh;
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = i[30] ? 32'($signed(a) >>> sh) : a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    return r;
  endfunction

  function automatic logic model_take(input logic [31:0] i, input logic [31:0] a,
                                      input logic [31:0] b);
    logic t;
    t = 1'b0;
    if (i[6:0] == 7'b1100011) begin
      case (i[14:12])
        3'd0: t = (a == b);
        3'd1: t = (a != b);
        3'd4: t = ($signed(a) < $signed(b));
        3'd5: t = ($signed(a) >= $signed(b));
        3'd6: t = (a < b);
        3'd7: t = (a >= b);
        default: t = 1'b0;
      endcase
    end
    return t;
  endfunction

  task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    inst = i;
    in_a = a;
    in_b = b;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    en     = 1'b1;
    apply(32'h0000_0033, 32'd2, 32'd3);
    @(posedge clk);
    #1;
    checks++;
    if (imm_q !== 32'h0 || result_q !== 32'h0 || take_b_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_q: imm_q=%h result_q=%h take_b_q=%b, expected all zero",
               imm_q, result_q, take_b_q);
    end
    checks++;
    if (result !== 32'd5) begin
      errors++;
      $display("FAIL reset_comb_result: got %h expected 00000005", result);
    end
  endtask

  task automatic test_imm();
    logic [31:0] vi [7];
    logic [31:0] ve [7];
    vi = '{32'hFFF0_0093, 32'h1234_50B7, 32'hFFDF_F06F, 32'h0000_0033,
           32'hFE00_0FA3, 32'h8000_0063, 32'hFFFF_F017};
    ve = '{32'hFFFF_FFFF, 32'h1234_5000, 32'hFFFF_FFFC, 32'h0000_0000,
           32'hFFFF_FFFF, 32'hFFFF_F000, 32'hFFFF_F000};
    for (int k = 0; k < 7; k++) begin
      apply(vi[k], 32'h0, 32'h0);
      checks++;
      if (imm !== ve[k]) begin
        errors++;
        $display("FAIL imm[%0d] inst=%h: got %h expected %h", k, vi[k], imm, ve[k]);
      end
    end
  endtask

  task automatic test_arith();
    logic [31:0] vi [5];
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] ve [5];
    vi = '{32'h4000_0033, 32'h4000_0013, 32'h0000_2033, 32'h0000_3033, 32'h0000_0033};
    va = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vb = '{32'd7, 32'd7, 32'd1, 32'd1, 32'd1};
    ve = '{32'hFFFF_FFFE, 32'd12, 32'd1, 32'd0, 32'd0};
    for (int k = 0; k < 5; k++) begin
      apply(vi[k], va[k], vb[k]);
      checks++;
      if (result !== ve[k]) begin
        errors++;
        $display("FAIL arith[%0d] inst=%h: got %h expected %h", k, vi[k], result, ve[k]);
      end
    end
  endtask

  task automatic test_shift();
    logic [31:0] vi [5];
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] ve [5];
    vi = '{32'h4000_5033, 32'h0000_5033, 32'h0000_1033, 32'h4000_1033, 32'h4000_5013};
    va = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'hC000_0001, 32'h7000_0000};
    vb = '{32'h24, 32'h24, 32'd31, 32'h21, 32'd4};
    ve = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h8000_0002, 32'h0700_0000};
    for (int k = 0; k < 5; k++) begin
      apply(vi[k], va[k], vb[k]);
      checks++;
      if (result !== ve[k]) begin
        errors++;
        $display("FAIL shift[%0d] inst=%h: got %h expected %h", k, vi[k], result, ve[k]);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] vi [8];
    logic        ve [8];
    vi = '{32'h0000_4063, 32'h0000_6063, 32'h0000_5063, 32'h0000_7063,
           32'h0000_1063, 32'h0000_0063, 32'h0000_2063, 32'h0000_4033};
    ve = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      apply(vi[k], 32'hFFFF_FFFF, 32'd1);
      checks++;
      if (take_b !== ve[k]) begin
        errors++;
        $display("FAIL branch[%0d] inst=%h: got %b expected %b", k, vi[k], take_b, ve[k]);
      end
    end
    apply(32'h0000_0063, 32'h1234_5678, 32'h1234_5678);
    checks++;
    if (take_b !== 1'b1) begin
      errors++;
      $display("FAIL branch_beq_equal: got %b expected 1", take_b);
    end
  endtask

  task automatic test_regs();
    resetn = 1'b1;
    en     = 1'b1;
    apply(32'h0000_0033, 32'd2, 32'd3);
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 32'd5 || imm_q !== 32'h0 || take_b_q !== 1'b0) begin
      errors++;
      $display("FAIL regs_load: result_q=%h imm_q=%h take_b_q=%b expected 00000005/00000000/0",
               result_q, imm_q, take_b_q);
    end
    en = 1'b0;
    apply(32'h0000_4063, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 32'd5 || take_b_q !== 1'b0) begin
      errors++;
      $display("FAIL regs_hold: result_q=%h take_b_q=%b expected 00000005/0", result_q, take_b_q);
    end
    en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 32'h0000_0000 || take_b_q !== 1'b1 || imm_q !== 32'h0000_0000) begin
      errors++;
      $display("FAIL regs_branch: result_q=%h take_b_q=%b imm_q=%h expected 00000000/1/00000000",
               result_q, take_b_q, imm_q);
    end
    apply(32'hFFDF_F06F, 32'h0000_1000, 32'd4);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 32'h0 || take_b_q !== 1'b0 || imm_q !== 32'h0) begin
      errors++;
      $display("FAIL regs_reset_priority: result_q=%h take_b_q=%b imm_q=%h expected zero",
               result_q, take_b_q, imm_q);
    end
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 32'h0000_1004 || imm_q !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL regs_jal: result_q=%h imm_q=%h expected 00001004/fffffffc", result_q, imm_q);
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [10];
    logic [31:0] ri;
    logic [31:0] ra;
    logic [31:0] rb;
    int          bad;
    ops = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011};
    bad = 0;
    for (int n = 0; n < 10000; n++) begin
      ri = $urandom;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(3, 0) != 0) ri[6:0] = ops[$urandom_range(9, 0)];
      if ($urandom_range(7, 0) == 0) rb = ra;
      apply(ri, ra, rb);
      checks++;
      if (imm !== model_imm(ri) || result !== model_alu(ri, ra, rb) ||
          take_b !== model_take(ri, ra, rb)) begin
        errors++;
        if (bad < 10) begin
          $display("FAIL random inst=%h a=%h b=%h: imm=%h/%h result=%h/%h take_b=%b/%b (got/expected)",
                   ri, ra, rb, imm, model_imm(ri), result, model_alu(ri, ra, rb),
                   take_b, model_take(ri, ra, rb));
        end
        bad++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    en     = 1'b0;
    inst   = '0;
    in_a   = '0;
    in_b   = '0;
    test_reset();
    resetn = 1'b1;
    test_imm();
    test_arith();
    test_shift();
    test_branch();
    test_regs();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
